// File: rtl/pixel_row_serializer.sv
// Purpose: buffers one pixel row and streams it out OUTPUT_BUS_PIXEL_WIDTH pixels per beat with SOF/EOL/EOF markers.
// Latency: row accepted at edge N presents beat 0 in the cycle after edge N; one beat per cycle, no gap between rows.
// Backpressure: beat held stable while DATA_OUT_READY is low; ROW_READY rises only when the buffer drains (zero-bubble hand-over).
module pixel_row_serializer #(
    parameter int WIDTH                  = 4,
    parameter int HEIGHT                 = 4,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int BIT_DEPTH              = 8
) (
    input  logic                                        SYSTEM_CLK,
    input  logic                                        SYSTEM_RESET_N,
    input  logic                                        ROW_VALID,
    input  logic [WIDTH*BIT_DEPTH-1:0]                  ROW_DATA,
    output logic                                        ROW_READY,
    input  logic                                        FLUSH,
    output logic                                        DATA_OUT_VALID,
    input  logic                                        DATA_OUT_READY,
    output logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_OUT,
    output logic                                        DATA_OUT_SOF,
    output logic                                        DATA_OUT_EOL,
    output logic                                        DATA_OUT_EOF,
    output logic [$clog2(HEIGHT)-1:0]                   ROW_INDEX
);

    localparam int BEATS  = WIDTH / OUTPUT_BUS_PIXEL_WIDTH;
    localparam int BEAT_W = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
    localparam int ROW_W  = WIDTH * BIT_DEPTH;
    // A single-beat row still needs a one-bit counter to keep the vector legal.
    localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RCW    = $clog2(HEIGHT);

    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [RCW-1:0] LAST_ROW  = RCW'(HEIGHT - 1);

    logic [ROW_W-1:0]  row_buf_q, row_buf_d;
    logic              full_q, full_d;
    logic [BCW-1:0]    beat_q, beat_d;
    logic [RCW-1:0]    row_q, row_d;

    logic              last_beat;
    logic              beat_acc;
    logic              last_beat_acc;
    logic              row_rdy;
    logic              row_acc;
    logic [BEAT_W-1:0] beat_dat;

    // Handshakes and next-state: flush wins, then the draining beat, then a new row overrides the drain.
    always_comb begin
        last_beat     = (beat_q == LAST_BEAT);
        beat_acc      = full_q & DATA_OUT_READY;
        last_beat_acc = beat_acc & last_beat;
        row_rdy       = SYSTEM_RESET_N & ~FLUSH & (~full_q | last_beat_acc);
        row_acc       = ROW_VALID & row_rdy;

        row_buf_d = row_buf_q;
        full_d    = full_q;
        beat_d    = beat_q;
        row_d     = row_q;

        if (FLUSH) begin
            full_d = 1'b0;
            beat_d = '0;
            row_d  = '0;
        end else begin
            if (beat_acc) begin
                if (last_beat) begin
                    full_d = 1'b0;
                    beat_d = '0;
                    row_d  = (row_q == LAST_ROW) ? '0 : row_q + RCW'(1);
                end else begin
                    beat_d = beat_q + BCW'(1);
                end
            end
            if (row_acc) begin
                row_buf_d = ROW_DATA;
                full_d    = 1'b1;
                beat_d    = '0;
            end
        end
    end

    // State registers; reset discards any partial row and restarts the frame at row 0.
    always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            row_buf_q <= '0;
            full_q    <= 1'b0;
            beat_q    <= '0;
            row_q     <= '0;
        end else begin
            row_buf_q <= row_buf_d;
            full_q    <= full_d;
            beat_q    <= beat_d;
            row_q     <= row_d;
        end
    end

    // Select the current beat's pixels from the row buffer, lowest pixel in lane 0.
    always_comb begin
        beat_dat = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BCW'(k)) begin
                beat_dat = row_buf_q[k*BEAT_W +: BEAT_W];
            end
        end
    end

    // Output bus and markers are forced to zero whenever no beat is held.
    always_comb begin
        ROW_READY      = row_rdy;
        DATA_OUT_VALID = full_q;
        DATA_OUT       = full_q ? beat_dat : '0;
        DATA_OUT_SOF   = full_q & (row_q == '0) & (beat_q == '0);
        DATA_OUT_EOL   = full_q & last_beat;
        DATA_OUT_EOF   = full_q & last_beat & (row_q == LAST_ROW);
        ROW_INDEX      = row_q;
    end

endmodule

// File: tb/tb_pixel_row_serializer.sv
// Purpose: exercises pixel_row_serializer with directed and random rows against a frame-level reference model.
// Latency: expected beats are queued once a row handshake completes and checked every cycle the output is observed.
// Backpressure: DATA_OUT_READY is driven high, low or randomly by a dedicated process.
module tb_pixel_row_serializer;

    localparam int W  = 4;
    localparam int OB = 2;
    localparam int H  = 2;
    localparam int BD = 8;
    localparam int B  = W / OB;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic        eof;
        logic [0:0]  idx;
        logic [15:0] dat;
    } beat_t;

    logic              clk;
    logic              SYSTEM_RESET_N;
    logic              ROW_VALID;
    logic [W*BD-1:0]   ROW_DATA;
    logic              ROW_READY;
    logic              FLUSH;
    logic              DATA_OUT_VALID;
    logic              DATA_OUT_READY;
    logic [OB*BD-1:0]  DATA_OUT;
    logic              DATA_OUT_SOF;
    logic              DATA_OUT_EOL;
    logic              DATA_OUT_EOF;
    logic [0:0]        ROW_INDEX;

    beat_t exp_q[$];
    int    model_row;
    int    rdy_mode;   // 0: ready high, 1: ready low, 2: random
    int    n_chk;
    int    n_fail;

    pixel_row_serializer #(
        .WIDTH(W), .HEIGHT(H), .OUTPUT_BUS_PIXEL_WIDTH(OB), .BIT_DEPTH(BD)
    ) dut (
        .SYSTEM_CLK(clk),
        .SYSTEM_RESET_N(SYSTEM_RESET_N),
        .ROW_VALID(ROW_VALID),
        .ROW_DATA(ROW_DATA),
        .ROW_READY(ROW_READY),
        .FLUSH(FLUSH),
        .DATA_OUT_VALID(DATA_OUT_VALID),
        .DATA_OUT_READY(DATA_OUT_READY),
        .DATA_OUT(DATA_OUT),
        .DATA_OUT_SOF(DATA_OUT_SOF),
        .DATA_OUT_EOL(DATA_OUT_EOL),
        .DATA_OUT_EOF(DATA_OUT_EOF),
        .ROW_INDEX(ROW_INDEX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: a row of W pixels becomes B beats of OB pixels; frame position is a row count modulo H.
    task automatic model_push_row(input logic [W*BD-1:0] row);
        beat_t e;
        for (int k = 0; k < B; k++) begin
            e.dat = 16'((row >> (k * OB * BD)) & 32'hFFFF);
            e.sof = (model_row == 0) && (k == 0);
            e.eol = (k == B - 1);
            e.eof = (k == B - 1) && (model_row == H - 1);
            e.idx = 1'(model_row);
            exp_q.push_back(e);
        end
        model_row = (model_row + 1) % H;
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_row = 0;
    endtask

    // One observation per cycle: the head of the queue must be on the bus whenever anything is pending.
    task automatic monitor_step();
        beat_t e;
        if (SYSTEM_RESET_N && !FLUSH) begin
            if (exp_q.size() == 0) begin
                chk("idle_out", {DATA_OUT_VALID, DATA_OUT_SOF, DATA_OUT_EOL, DATA_OUT_EOF, DATA_OUT}, 64'd0);
            end else begin
                e = exp_q[0];
                chk("beat", {DATA_OUT_VALID, DATA_OUT_SOF, DATA_OUT_EOL, DATA_OUT_EOF, ROW_INDEX, DATA_OUT},
                    {1'b1, e.sof, e.eol, e.eof, e.idx, e.dat});
                if (DATA_OUT_VALID && DATA_OUT_READY) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic send_row(input logic [W*BD-1:0] row);
        bit got;
        got = 0;
        ROW_VALID = 1'b1;
        ROW_DATA  = row;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ROW_READY) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("row_accept_timeout", 64'd0, 64'd1);
            ROW_VALID = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_push_row(row);
            ROW_VALID = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !DATA_OUT_VALID) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        rdy_mode       = 0;
        model_row      = 0;
        SYSTEM_RESET_N = 1'b0;
        ROW_VALID      = 1'b0;
        ROW_DATA       = '0;
        FLUSH          = 1'b0;

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            begin
                DATA_OUT_READY = 1'b1;
                forever begin
                    @(posedge clk);
                    #2;
                    case (rdy_mode)
                        0:       DATA_OUT_READY = 1'b1;
                        1:       DATA_OUT_READY = 1'b0;
                        default: DATA_OUT_READY = ($urandom_range(0, 3) != 0);
                    endcase
                end
            end
        join_none

        // Reset held for three cycles: everything quiet, no row accepted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {DATA_OUT_VALID, DATA_OUT_SOF, DATA_OUT_EOL, DATA_OUT_EOF, ROW_INDEX, DATA_OUT}, 64'd0);
        chk("rst_row_ready", 64'(ROW_READY), 64'd0);
        @(posedge clk);
        #1;
        SYSTEM_RESET_N = 1'b1;
        @(negedge clk);
        chk("post_rst_row_ready", 64'(ROW_READY), 64'd1);
        @(posedge clk);
        #1;

        // Single row with the consumer always ready.
        send_row(32'h44332211);
        wait_idle();

        // Backpressure on beat 0 for three cycles.
        rdy_mode = 1;
        send_row(32'h44332211);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            chk("bp_hold_dat", 64'(DATA_OUT), 64'h2211);
            chk("bp_hold_vld", 64'(DATA_OUT_VALID), 64'd1);
            chk("bp_row_ready", 64'(ROW_READY), 64'd0);
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_idle();

        // Three rows back to back across a frame boundary.
        send_row(32'h44332211);
        send_row(32'h88776655);
        send_row(32'hCCBBAA99);
        wait_idle();
        // The third row started a new frame; finish it so the next test begins at row 0.
        send_row(32'h00000000);
        wait_idle();

        // Flush after the first beat is accepted: the second beat must never appear.
        send_row(32'h44332211);
        @(posedge clk);
        #1;
        FLUSH = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        FLUSH = 1'b0;
        @(negedge clk);
        chk("flush_vld", 64'(DATA_OUT_VALID), 64'd0);
        @(posedge clk);
        #1;
        send_row(32'hDDCCBBAA);
        wait_idle();
        // Complete that frame so the reset test begins at row 0.
        send_row(32'h0F0E0D0C);
        wait_idle();

        // Asynchronous reset in the middle of beat 1 of row 1.
        send_row(32'h44332211);
        send_row(32'h88776655);
        @(posedge clk);
        #2;
        SYSTEM_RESET_N = 1'b0;
        model_clear();
        #1;
        chk("arst_outputs", {DATA_OUT_VALID, DATA_OUT_SOF, DATA_OUT_EOL, DATA_OUT_EOF, ROW_INDEX, DATA_OUT}, 64'd0);
        chk("arst_row_ready", 64'(ROW_READY), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        SYSTEM_RESET_N = 1'b1;
        send_row(32'h13579BDF);
        wait_idle();

        // Random rows, random gaps and random consumer stalls.
        rdy_mode = 2;
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_row($urandom);
        end
        rdy_mode = 0;
        wait_idle();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
